dcache_store_port: RTL

DCACHE_STORE_PORT -- requirements
Module: dcache_store_port

---
 rtl/dcache_store_port.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_store_port.sv
// Store port of a direct-mapped, write-back data cache with a single memory port.
// Optional macro STORE_WRITE_ALLOCATE_EN: misses allocate (WRITEBACK/FILL/WRITE) instead of MEMWRITE.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif

module dcache_store_port #(
  parameter int LINES            = 4,
  parameter int LINE_SIZE        = 128,
  parameter int WORD_SIZE        = `WORD_SIZE,
  parameter int WIDTH            = `ADDRESS_WIDTH,
  parameter int SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cache_wenable,
  input  logic [WIDTH-1:0]            cache_physical_address,
  input  logic [WORD_SIZE-1:0]        cache_store_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
  output logic                        store_success,
  output logic                        busy,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [WIDTH-1:0]            mem_addr,
  output logic [LINE_SIZE-1:0]        mem_wdata,
  output logic [LINE_SIZE/8-1:0]      mem_wmask,
  input  logic                        mem_ready,
  input  logic [LINE_SIZE-1:0]        mem_rdata
);
  localparam int IW = $clog2(LINES);
  localparam int TW = WIDTH - 4 - IW;
  localparam int NB = LINE_SIZE / 8;

  typedef enum logic [2:0] {IDLE, WRITEBACK, FILL, WRITE, MEMWRITE} state_t;

  state_t                      r_state, w_next;
  logic [LINES-1:0]            r_valid, r_dirty;
  logic [TW-1:0]               r_tag  [LINES];
  logic [LINE_SIZE-1:0]        r_line [LINES];
  logic [WIDTH-1:0]            r_addr;
  logic [WORD_SIZE-1:0]        r_value;
  logic [SIZE_WRITE_WIDTH-1:0] r_size;
  logic                        r_success;

  logic                        w_idle, w_accept, w_hit, w_set_success;
  logic [WIDTH-1:0]            w_addr, w_line_addr, w_victim_addr;
  logic [WORD_SIZE-1:0]        w_value;
  logic [SIZE_WRITE_WIDTH-1:0] w_size;
  logic [IW-1:0]               w_idx;
  logic [TW-1:0]               w_tag;
  logic [NB-1:0]               w_st_mask;
  logic [LINE_SIZE-1:0]        w_st_data, w_merged;

  // In IDLE the live request is looked up directly; afterwards the latched copy is used.
  assign w_idle        = (r_state == IDLE);
  assign w_accept      = w_idle && cache_wenable && !r_success;
  assign w_addr        = w_idle ? cache_physical_address : r_addr;
  assign w_value       = w_idle ? cache_store_value : r_value;
  assign w_size        = w_idle ? cache_store_size : r_size;
  assign w_idx         = w_addr[IW+3:4];
  assign w_tag         = w_addr[WIDTH-1:IW+4];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line_addr   = {w_addr[WIDTH-1:4], 4'b0000};
  assign w_victim_addr = {r_tag[w_idx], w_idx, 4'b0000};
  assign busy          = !w_idle;
  assign store_success = r_success;

  always_comb begin
    w_st_mask = '0;
    w_st_data = '0;
    if (w_size == `BYTE_SIZE) begin
      w_st_mask = NB'(1) << w_addr[3:0];
      w_st_data = LINE_SIZE'(w_value[7:0]) << {w_addr[3:0], 3'b000};
    end else begin
      w_st_mask = NB'(4'hF) << {w_addr[3:2], 2'b00};
      w_st_data = LINE_SIZE'(w_value[31:0]) << {w_addr[3:2], 5'b00000};
    end
    w_merged = r_line[w_idx];
    for (int unsigned b = 0; b < NB; b++) begin
      if (w_st_mask[b]) w_merged[b*8 +: 8] = w_st_data[b*8 +: 8];
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_success = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_set_success = 1'b1;
          end else begin
`ifdef STORE_WRITE_ALLOCATE_EN
            w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : FILL;
`else
            w_next = MEMWRITE;
`endif
          end
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_victim_addr;
        mem_wdata = r_line[w_idx];
        mem_wmask = '1;
        if (mem_ready) w_next = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = w_line_addr;
        if (mem_ready) w_next = WRITE;
      end
      WRITE: begin
        w_set_success = 1'b1;
        w_next        = IDLE;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_line_addr;
        mem_wdata = w_st_data;
        mem_wmask = w_st_mask;
        if (mem_ready) begin
          w_set_success = 1'b1;
          w_next        = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_success <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_success <= w_set_success;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= cache_physical_address;
      r_value <= cache_store_value;
      r_size  <= cache_store_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if ((w_accept && w_hit) || (r_state == WRITE)) begin
        r_line[w_idx]  <= w_merged;
        r_dirty[w_idx] <= 1'b1;
      end else if ((r_state == FILL) && mem_ready) begin
        r_line[w_idx]  <= mem_rdata;
        r_tag[w_idx]   <= w_tag;
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end
endmodule
